halt_controller: RTL and testbench
==================================

// Module: halt_controller
// PURPOSE
//  Parametrised run/step/breakpoint halt controller for the EDiC CPU clock domain.
//  Gates execution through o_halt in one of three modes:
//  - free run;
//  - step N clock cycles per button press;
//  - step N instructions per button press.
//  Adds debounced button input and NUM_BP maskable breakpoint channels with hit
//  reporting. Breakpoint suppression lets the CPU resume past a breakpoint.
// PARAMETERS
//  NUM_BP          4   number of breakpoint channels (>=1)
//  SYNC_STAGES     2   synchroniser flops on button/switch inputs (>=2)
//  DEBOUNCE_CYCLES 16  consecutive stable samples before button state is accepted (>=1)
//  STEP_CNT_WIDTH  8   width of step count
// PORTS
//  i_clk                in  1                 system clock, all logic on rising edge
//  i_reset              in  1                 synchronous reset, active-high
//  i_btnStep            in  1                 async step button, 1 = pressed
//  i_swStepNRun         in  1                 async switch, 1 = step mode, 0 = run mode
//  i_swInstrNCycle      in  1                 async switch, 1 = instruction step, 0 = cycle step
//  i_stepCount          in  STEP_CNT_WIDTH    units per step press, sampled at the press; 0 treated as 1
//  i_bpEnable           in  NUM_BP            per-channel breakpoint enable (synchronous)
//  i_breakpointHit      in  NUM_BP            per-channel hit, synchronous, active-high
//  i_instrFinished      in  1                 1-cycle pulse on the last cycle of an instruction
//  o_halt               out 1                 1 = CPU must not advance this cycle
//  o_bpHitValid         out 1                 1 while halted by a breakpoint
//  o_bpHitId            out clog2(NUM_BP)>=1  lowest hit channel index, latched on the hit
//  o_stepBusy           out 1                 1 while a step burst is executing
//  o_breakpointEnable   out NUM_BP            = i_bpEnable when not suppressed, else 0
// BEHAVIOUR
//  Input conditioning
//  - Button and switches pass through SYNC_STAGES flops.
//  - Debounce: counter resets on any change of the synced button. Debounced level
//    updates after DEBOUNCE_CYCLES equal samples.
//  - stepPulse: 1-cycle pulse on a debounced 0->1 transition only.
//  - Breakpoint qualification: qHit = i_breakpointHit & i_bpEnable & ~suppress.
//  - suppress sets on any exit from BP_HALT. It clears on the next i_instrFinished
//    with o_halt=0.
//  FSM states
//  - IDLE    o_halt=1. Next state is RUN if synced StepNRun=0. On stepPulse: load rem,
//            go to STEP.
//  - RUN     o_halt=|qHit. On a hit: go to BP_HALT. Else if StepNRun=1: go to IDLE.
//  - STEP    o_halt=|qHit, o_stepBusy=1.
//            - On a hit: go to BP_HALT and abort the remaining count.
//            - Cycle mode: rem decrements every cycle with o_halt=0.
//            - Instr mode: rem decrements on each i_instrFinished with o_halt=0.
//            - When the decrement takes rem from 1 to 0, go to IDLE.
//            - StepNRun=0 mid-burst: go to RUN, rem cleared.
//  - BP_HALT o_halt=1, o_bpHitValid=1. Leaves only on stepPulse, with suppress set:
//            - run mode: go to RUN;
//            - step mode: load rem, go to STEP.
//  Hit latching and precedence
//  - o_bpHitId is latched on the cycle qHit!=0 in RUN/STEP. It holds until the next hit.
//  - A qualified hit halts combinationally in the same cycle; that cycle does not
//    count toward rem.
//  - Hit and final decrement in the same cycle: BP_HALT wins.
//  - stepPulse while in STEP or RUN is ignored; it does not extend or restart a burst.
//  - The InstrNCycle switch is sampled continuously. A change mid-burst changes the
//    decrement rule from the next cycle; rem is kept.
//  Reset values
//  - i_reset (sync, dominant) gives:
//    - state=IDLE, rem=0, suppress=0, o_halt=1, o_bpHitValid=0, o_bpHitId=0, o_stepBusy=0;
//    - sync and debounce registers 0.
//  - After reset deasserts with StepNRun=0, RUN is reached after the synchroniser
//    latency (SYNC_STAGES) plus one cycle.
//  - Reset mid-burst or in BP_HALT discards the count and the hit info.
// TESTING
//  1 Reset, step mode, cycle mode, i_stepCount=3, clean press -> o_halt=0 exactly 3
//    consecutive cycles, o_stepBusy high for those 3, then IDLE with o_halt=1.
//  2 Button bouncing 0/1 every 3 cycles for 40 cycles, then held high
//    (DEBOUNCE_CYCLES=16) -> exactly one burst, starting 16+SYNC_STAGES+1 cycles after
//    the stable edge.
//  3 Instr mode, i_stepCount=2, i_instrFinished every 4th cycle -> o_halt low until
//    the 2nd pulse, high from the next cycle; i_stepCount=0 -> one instruction.
//  4 Run mode, i_bpEnable=4'b0110, i_breakpointHit=4'b1110 -> o_halt=1 same cycle,
//    o_bpHitId=1, o_bpHitValid=1; press -> RUN, same hit held ignored until
//    i_instrFinished.
//  5 Step burst of 5 cycles, hit on the 3rd -> BP_HALT after 2 counted cycles;
//    hit and final decrement together -> BP_HALT.
//  6 Run mode, flip StepNRun=1 -> IDLE after sync latency; assert i_reset in
//    STEP/BP_HALT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/halt_controller.sv
`default_nettype none
// ============================================================================
// Module      : halt_controller
// Description : Run / step-N / breakpoint halt controller with debounced step
//               button and maskable, suppressible breakpoint channels.
// Revision    : 1.0 - initial release
// ============================================================================
module halt_controller #(
    parameter int NUM_BP          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STEP_CNT_WIDTH  = 8,
    localparam int BP_ID_W        = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_btnStep,
    input  logic                      i_swStepNRun,
    input  logic                      i_swInstrNCycle,
    input  logic [STEP_CNT_WIDTH-1:0] i_stepCount,
    input  logic [NUM_BP-1:0]         i_bpEnable,
    input  logic [NUM_BP-1:0]         i_breakpointHit,
    input  logic                      i_instrFinished,
    output logic                      o_halt,
    output logic                      o_bpHitValid,
    output logic [BP_ID_W-1:0]        o_bpHitId,
    output logic                      o_stepBusy,
    output logic [NUM_BP-1:0]         o_breakpointEnable
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_BP   = 2'd3;

    logic [SYNC_STAGES-1:0]    r_btnSync, r_snrSync, r_incSync;
    logic [DB_W-1:0]           r_dbCnt;
    logic                      r_dbLevel, r_dbLevelD;
    logic [WARM_W-1:0]         r_warm;
    logic [1:0]                r_state;
    logic [STEP_CNT_WIDTH-1:0] r_rem;
    logic                      r_suppress;
    logic [BP_ID_W-1:0]        r_bpHitId;

    logic                      w_btnS, w_snr, w_instrMode, w_syncValid, w_stepPulse;
    logic [NUM_BP-1:0]         w_qHit;
    logic                      w_anyHit;
    logic [BP_ID_W-1:0]        w_hitId;
    logic [STEP_CNT_WIDTH-1:0] w_load;
    logic [1:0]                w_next;
    logic [STEP_CNT_WIDTH-1:0] w_remNext;
    logic                      w_halt, w_setSupp, w_latchHit, w_dec;

    assign w_btnS      = r_btnSync[SYNC_STAGES-1];
    assign w_snr       = r_snrSync[SYNC_STAGES-1];
    assign w_instrMode = r_incSync[SYNC_STAGES-1];
    // Synced switch levels are only trusted once the chain holds real samples.
    assign w_syncValid = (r_warm == WARM_W'(SYNC_STAGES));
    assign w_stepPulse = r_dbLevel & ~r_dbLevelD;
    assign w_qHit      = i_breakpointHit & i_bpEnable & {NUM_BP{~r_suppress}};
    assign w_anyHit    = |w_qHit;
    assign w_load      = (i_stepCount == '0) ? STEP_CNT_WIDTH'(1) : i_stepCount;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_btnSync  <= '0;
            r_snrSync  <= '0;
            r_incSync  <= '0;
            r_dbCnt    <= '0;
            r_dbLevel  <= 1'b0;
            r_dbLevelD <= 1'b0;
            r_warm     <= '0;
        end else begin
            r_btnSync  <= {r_btnSync[SYNC_STAGES-2:0], i_btnStep};
            r_snrSync  <= {r_snrSync[SYNC_STAGES-2:0], i_swStepNRun};
            r_incSync  <= {r_incSync[SYNC_STAGES-2:0], i_swInstrNCycle};
            r_dbLevelD <= r_dbLevel;
            if (!w_syncValid) begin
                r_warm <= r_warm + WARM_W'(1);
            end
            // Count consecutive samples that disagree with the accepted level.
            if (w_btnS == r_dbLevel) begin
                r_dbCnt <= '0;
            end else if (r_dbCnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_dbCnt   <= '0;
                r_dbLevel <= w_btnS;
            end else begin
                r_dbCnt <= r_dbCnt + DB_W'(1);
            end
        end
    end

    always_comb begin
        w_hitId = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_qHit[i]) begin
                w_hitId = BP_ID_W'(i);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_remNext  = r_rem;
        w_halt     = 1'b1;
        w_setSupp  = 1'b0;
        w_latchHit = 1'b0;
        w_dec      = w_instrMode ? i_instrFinished : 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_syncValid && !w_snr) begin
                    w_next = ST_RUN;
                end else if (w_stepPulse) begin
                    w_remNext = w_load;
                    w_next    = ST_STEP;
                end
            end
            ST_RUN: begin
                w_halt = w_anyHit;
                if (w_anyHit) begin
                    w_latchHit = 1'b1;
                    w_next     = ST_BP;
                end else if (w_snr) begin
                    w_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                // A hit wins over both a mode change and the final decrement.
                w_halt = w_anyHit;
                if (w_anyHit) begin
                    w_latchHit = 1'b1;
                    w_remNext  = '0;
                    w_next     = ST_BP;
                end else if (!w_snr) begin
                    w_remNext = '0;
                    w_next    = ST_RUN;
                end else if (w_dec) begin
                    w_remNext = r_rem - STEP_CNT_WIDTH'(1);
                    if (r_rem == STEP_CNT_WIDTH'(1)) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_BP: begin
                if (w_stepPulse) begin
                    w_setSupp = 1'b1;
                    if (w_snr) begin
                        w_remNext = w_load;
                        w_next    = ST_STEP;
                    end else begin
                        w_next = ST_RUN;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_suppress <= 1'b0;
            r_bpHitId  <= '0;
        end else begin
            r_state <= w_next;
            r_rem   <= w_remNext;
            if (w_setSupp) begin
                r_suppress <= 1'b1;
            end else if (i_instrFinished && !w_halt) begin
                r_suppress <= 1'b0;
            end
            if (w_latchHit) begin
                r_bpHitId <= w_hitId;
            end
        end
    end

    assign o_halt             = w_halt;
    assign o_bpHitValid       = (r_state == ST_BP);
    assign o_bpHitId          = r_bpHitId;
    assign o_stepBusy         = (r_state == ST_STEP);
    assign o_breakpointEnable = r_suppress ? '0 : i_bpEnable;

endmodule
`default_nettype wire

// File: tb/tb_halt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_halt_controller
// Description : Directed self-checking bench for halt_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_halt_controller;

    localparam int SS  = 2;
    localparam int DB  = 16;
    localparam int LAT = DB + SS + 1;

    logic       clk = 1'b0;
    logic       reset, btn, snr, inc, instrFin;
    logic [7:0] stepCount;
    logic [3:0] bpEn, hit;
    logic       halt, hitValid, busy;
    logic [1:0] hitId;
    logic [3:0] bpOut;

    int checks = 0;
    int errors = 0;

    halt_controller #(
        .NUM_BP(4), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .STEP_CNT_WIDTH(8)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_btnStep(btn), .i_swStepNRun(snr),
        .i_swInstrNCycle(inc), .i_stepCount(stepCount), .i_bpEnable(bpEn),
        .i_breakpointHit(hit), .i_instrFinished(instrFin), .o_halt(halt),
        .o_bpHitValid(hitValid), .o_bpHitId(hitId), .o_stepBusy(busy),
        .o_breakpointEnable(bpOut)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic stepMode, input logic instrMode);
        btn = 1'b0; hit = '0; instrFin = 1'b0; snr = stepMode; inc = instrMode;
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        repeat (SS + 4) tick;
    endtask

    // Holds the button (optionally bouncing first) and records the halt profile.
    task automatic burst(input int n, input int bouncePer, input int bounceLen, input int instrPer,
                         output int nLow, output int firstLow, output int lastLow, output int busyErr);
        nLow = 0; firstLow = -1; lastLow = -1; busyErr = 0;
        btn = 1'b1; instrFin = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick;
            if (!halt) begin
                nLow++;
                if (firstLow < 0) firstLow = k;
                lastLow = k;
            end
            if (busy !== !halt) busyErr++;
            btn      = (k < bounceLen) ? (((k / bouncePer) % 2) == 0) : 1'b1;
            instrFin = (instrPer > 0) && (k % instrPer == 0);
        end
        instrFin = 1'b0; btn = 1'b0;
        repeat (DB + SS + 4) tick;
    endtask

    task automatic test_reset;
        reset = 1'b1; btn = 1'b0; snr = 1'b1; inc = 1'b0; instrFin = 1'b0;
        stepCount = 8'd3; bpEn = 4'b1010; hit = 4'b0000;
        tick; tick; tick;
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL reset_halt got %b want 1", halt); end
        checks++; if (hitValid !== 1'b0) begin errors++; $display("FAIL reset_hitValid got %b want 0", hitValid); end
        checks++; if (hitId !== 2'd0) begin errors++; $display("FAIL reset_hitId got %0d want 0", hitId); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (bpOut !== 4'b1010) begin errors++; $display("FAIL reset_bpEnable got %b want 1010", bpOut); end
    endtask

    task automatic test_cycle_step;
        int nLow, firstLow, lastLow, busyErr;
        do_reset(1'b1, 1'b0);
        stepCount = 8'd3;
        burst(30, 1, 0, 0, nLow, firstLow, lastLow, busyErr);
        checks++; if (nLow !== 3) begin errors++; $display("FAIL cyc_nLow got %0d want 3", nLow); end
        checks++; if (firstLow !== LAT) begin errors++; $display("FAIL cyc_first got %0d want %0d", firstLow, LAT); end
        checks++; if (lastLow !== LAT + 2) begin errors++; $display("FAIL cyc_last got %0d want %0d", lastLow, LAT + 2); end
        checks++; if (busyErr !== 0) begin errors++; $display("FAIL cyc_busy got %0d want 0", busyErr); end
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL cyc_idle_halt got %b want 1", halt); end
    endtask

    task automatic test_debounce;
        int nLow, firstLow, lastLow, busyErr;
        do_reset(1'b1, 1'b0);
        stepCount = 8'd1;
        burst(70, 3, 40, 0, nLow, firstLow, lastLow, busyErr);
        checks++; if (nLow !== 1) begin errors++; $display("FAIL db_nLow got %0d want 1", nLow); end
        checks++; if (firstLow !== 40 + LAT) begin errors++; $display("FAIL db_first got %0d want %0d", firstLow, 40 + LAT); end
    endtask

    task automatic test_instr_step;
        int nLow, firstLow, lastLow, busyErr;
        do_reset(1'b1, 1'b1);
        stepCount = 8'd2;
        burst(35, 1, 0, 4, nLow, firstLow, lastLow, busyErr);
        checks++; if (nLow !== 6) begin errors++; $display("FAIL instr2_nLow got %0d want 6", nLow); end
        checks++; if (firstLow !== LAT) begin errors++; $display("FAIL instr2_first got %0d want %0d", firstLow, LAT); end
        checks++; if (lastLow !== 24) begin errors++; $display("FAIL instr2_last got %0d want 24", lastLow); end
        stepCount = 8'd0;
        burst(35, 1, 0, 4, nLow, firstLow, lastLow, busyErr);
        checks++; if (nLow !== 2) begin errors++; $display("FAIL instr0_nLow got %0d want 2", nLow); end
        checks++; if (lastLow !== 20) begin errors++; $display("FAIL instr0_last got %0d want 20", lastLow); end
    endtask

    task automatic test_run_breakpoint;
        do_reset(1'b0, 1'b0);
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL run_free got %b want 0", halt); end
        bpEn = 4'b0110; hit = 4'b1110;
        #1;
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL run_hit_comb got %b want 1", halt); end
        tick;
        checks++; if (hitValid !== 1'b1) begin errors++; $display("FAIL run_bp_valid got %b want 1", hitValid); end
        checks++; if (hitId !== 2'd1) begin errors++; $display("FAIL run_bp_id got %0d want 1", hitId); end
        checks++; if (bpOut !== 4'b0110) begin errors++; $display("FAIL run_bpEn got %b want 0110", bpOut); end
        btn = 1'b1;
        repeat (LAT) tick;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL resume_halt got %b want 0", halt); end
        checks++; if (bpOut !== 4'b0000) begin errors++; $display("FAIL resume_bpEn got %b want 0000", bpOut); end
        instrFin = 1'b1;
        tick;
        instrFin = 1'b0;
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL rehit_halt got %b want 1", halt); end
        tick;
        checks++; if (hitValid !== 1'b1) begin errors++; $display("FAIL rehit_valid got %b want 1", hitValid); end
        btn = 1'b0; hit = '0;
    endtask

    task automatic test_step_breakpoint;
        do_reset(1'b1, 1'b0);
        bpEn = 4'b1111; stepCount = 8'd5; btn = 1'b1;
        repeat (LAT - 1) tick;
        tick;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL sbp_c1 got %b want 0", halt); end
        tick;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL sbp_c2 got %b want 0", halt); end
        tick;
        hit = 4'b1000;
        #1;
        checks++; if (halt !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL sbp_c3 got halt=%b busy=%b want 1 1", halt, busy); end
        tick;
        checks++; if (hitValid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sbp_state got valid=%b busy=%b want 1 0", hitValid, busy); end
        checks++; if (hitId !== 2'd3) begin errors++; $display("FAIL sbp_id got %0d want 3", hitId); end
        reset = 1'b1; btn = 1'b0;
        tick;
        reset = 1'b0;
        checks++; if (halt !== 1'b1 || hitValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_reset got halt=%b valid=%b busy=%b want 1 0 0", halt, hitValid, busy); end
        checks++; if (hitId !== 2'd0 || bpOut !== 4'b1111) begin
            errors++; $display("FAIL bp_reset_id got id=%0d en=%b want 0 1111", hitId, bpOut); end

        do_reset(1'b1, 1'b0);
        stepCount = 8'd1; btn = 1'b1;
        repeat (LAT - 1) tick;
        hit = 4'b0100;
        tick;
        checks++; if (halt !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL final_hit got halt=%b busy=%b want 1 1", halt, busy); end
        tick;
        checks++; if (hitValid !== 1'b1 || hitId !== 2'd2) begin
            errors++; $display("FAIL final_bp got valid=%b id=%0d want 1 2", hitValid, hitId); end
        btn = 1'b0; hit = '0;
    endtask

    task automatic test_mode_and_reset;
        do_reset(1'b1, 1'b0);
        stepCount = 8'd10; btn = 1'b1;
        repeat (LAT + 1) tick;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        reset = 1'b1; btn = 1'b0;
        tick;
        reset = 1'b0;
        checks++; if (halt !== 1'b1 || busy !== 1'b0 || hitValid !== 1'b0) begin
            errors++; $display("FAIL step_reset got halt=%b busy=%b valid=%b want 1 0 0", halt, busy, hitValid); end

        snr = 1'b0; reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        repeat (SS) tick;
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL warm_halt got %b want 1", halt); end
        tick;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL warm_run got %b want 0", halt); end
        snr = 1'b1;
        repeat (SS) tick;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL flip_still_run got %b want 0", halt); end
        tick;
        checks++; if (halt !== 1'b1) begin errors++; $display("FAIL flip_idle got %b want 1", halt); end
    endtask

    initial begin
        test_reset;
        test_cycle_step;
        test_debounce;
        test_instr_step;
        test_run_breakpoint;
        test_step_breakpoint;
        test_mode_and_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
